// File: rtl/alu_pkg.sv
// Shared op-code, FSM state and iterative-mode definitions for the sequential ALU.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_NOT   = 4'd2,
        OP_SHL   = 4'd3,
        OP_SHR   = 4'd4,
        OP_AND   = 4'd5,
        OP_OR    = 4'd6,
        OP_GTU   = 4'd7,
        OP_MUL   = 4'd8,
        OP_DIVU  = 4'd9,
        OP_REMU  = 4'd10,
        OP_SRA   = 4'd11,
        OP_XOR   = 4'd12,
        OP_LTS   = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } iter_mode_e;

    // Ops that run through the bit-serial unit instead of completing in one cycle.
    function automatic logic is_iter_op(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Bit-serial multiply (shift-add) and restoring divide, one bit per cycle.
// hi/lo form a double-width working register: for MUL it is {partial, multiplier},
// for DIV it is {remainder, dividend/quotient}. Outputs show the value after the
// step taken in the current cycle, so the final result is usable while done=1.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  iter_mode_e         mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    iter_mode_e       mode_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;

    // One step of shift-add multiply or restoring divide from the current registers.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        rem_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
        hi_n     = hi_q;
        lo_n     = lo_q;
        if (mode_q == MODE_MUL) begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH+1]) begin
            hi_n = div_diff[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_n = rem_sh[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Load operands on start, then advance one bit per cycle until the down-counter empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            mode_q <= MODE_MUL;
            cnt_q  <= '0;
        end else if (start) begin
            hi_q   <= '0;
            lo_q   <= a;
            opnd_q <= b;
            mode_q <= mode;
            cnt_q  <= CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            hi_q   <= hi_n;
            lo_q   <= lo_n;
            cnt_q  <= cnt_q - 1'b1;
        end
    end

    // Terminal count: the step happening in this cycle is the last one.
    assign done      = (cnt_q == CNT_W'(1));
    assign product   = {hi_n, lo_n};
    assign quotient  = lo_n;
    assign remainder = hi_n;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle ops are
// computed from the request fields at acceptance; MUL/DIVU/REMU use alu_iter_unit.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a request (in_ready=1)
//   BUSY    | bit-serial MUL/DIVU/REMU running, WIDTH cycles
//   DONE    | result and flags presented (out_valid=1) until out_ready
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             err
);

    localparam int               MSB     = WIDTH - 1;
    localparam logic [WIDTH-1:0] WIDTH_B = WIDTH'(WIDTH);

    state_e           state_q;
    op_e              op_q;
    logic             b_zero_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             carry_q;
    logic             negative_q;
    logic             overflow_q;
    logic             err_q;
    logic             out_valid_q;

    logic             iter_start;
    iter_mode_e       iter_mode;
    logic             it_done;
    logic [2*WIDTH-1:0] it_product;
    logic [WIDTH-1:0] it_quotient;
    logic [WIDTH-1:0] it_remainder;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] sub_diff;
    logic             shift_big;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;
    logic             sc_err;

    logic [WIDTH-1:0] it_res;
    logic             it_v;
    logic             it_err;

    assign in_ready   = (state_q == ST_IDLE);
    assign iter_start = in_ready && in_valid && is_iter_op(op);
    assign iter_mode  = (op == OP_MUL) ? MODE_MUL : MODE_DIV;

    alu_iter_unit #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (iter_start),
        .mode      (iter_mode),
        .a         (a),
        .b         (b),
        .done      (it_done),
        .product   (it_product),
        .quotient  (it_quotient),
        .remainder (it_remainder)
    );

    // Single-cycle result, carry/borrow and overflow straight from the request fields.
    always_comb begin
        add_sum   = {1'b0, a} + {1'b0, b};
        sub_diff  = a - b;
        shift_big = (b >= WIDTH_B);
        sc_res    = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        sc_err    = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_c   = add_sum[WIDTH];
                sc_v   = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sc_res = sub_diff;
                sc_c   = (a < b);
                sc_v   = (a[MSB] != b[MSB]) && (sub_diff[MSB] != a[MSB]);
            end
            OP_NOT: sc_res = ~a;
            OP_SHL: sc_res = shift_big ? '0 : (a << b);
            OP_SHR: sc_res = shift_big ? '0 : (a >> b);
            OP_SRA: sc_res = shift_big ? {WIDTH{a[MSB]}} : WIDTH'($signed(a) >>> b);
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_GTU: sc_res = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_LTS: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MUL, OP_DIVU, OP_REMU: sc_res = '0;
            default: begin
                sc_res = '0;
                sc_err = 1'b1;
            end
        endcase
    end

    // Iterative result selection; restoring division by zero naturally yields
    // all-ones quotient and remainder==a, so only err needs the zero-divisor flag.
    always_comb begin
        it_res = '0;
        it_v   = 1'b0;
        it_err = 1'b0;
        case (op_q)
            OP_MUL: begin
                it_res = it_product[WIDTH-1:0];
                it_v   = |it_product[2*WIDTH-1:WIDTH];
            end
            OP_DIVU: begin
                it_res = it_quotient;
                it_err = b_zero_q;
            end
            OP_REMU: begin
                it_res = it_remainder;
                it_err = b_zero_q;
            end
            default: it_res = '0;
        endcase
    end

    // Handshake FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            b_zero_q    <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            negative_q  <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q     <= op_e'(op);
                        b_zero_q <= (b == '0);
                        if (is_iter_op(op)) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= sc_res;
                            zero_q      <= (sc_res == '0);
                            carry_q     <= sc_c;
                            negative_q  <= sc_res[MSB];
                            overflow_q  <= sc_v;
                            err_q       <= sc_err;
                        end
                    end
                end
                ST_BUSY: begin
                    if (it_done) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= it_res;
                        zero_q      <= (it_res == '0);
                        carry_q     <= 1'b0;
                        negative_q  <= it_res[MSB];
                        overflow_q  <= it_v;
                        err_q       <= it_err;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign negative  = negative_q;
    assign overflow  = overflow_q;
    assign err       = err_q;

endmodule
